// File: rtl/fifo_synch_ctl.sv
// Synchronous FIFO with simultaneous read/write, registered or FWFT read,
// watermark flags, occupancy count and overflow/underflow error pulses.
module fifo_synch_ctl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         write_en,
    input  logic                         read_en,
    input  logic [DATA_WIDTH-1:0]        d_in,
    output logic [DATA_WIDTH-1:0]        d_out,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, unf_q;
    logic          wr_acc, rd_acc;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    assign wr_acc = write_en && !full;
    assign rd_acc = read_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = ptr_nxt(wr_ptr_q);
        if (rd_acc) rd_ptr_d = ptr_nxt(rd_ptr_q);
        if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
        else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= write_en && full;
            unf_q    <= read_en && empty;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && wr_acc) mem[wr_ptr_q] <= d_in;
    end

    if (FWFT == 0) begin : g_reg
        logic [DATA_WIDTH-1:0] dout_q, dout_d;
        logic                  valid_q;

        always_comb begin
            dout_d = dout_q;
            if (rd_acc) dout_d = mem[rd_ptr_q];
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                dout_q  <= dout_d;
                valid_q <= rd_acc;
            end
        end

        assign d_out = dout_q;
        assign valid = valid_q;
    end else begin : g_fwft
        assign d_out = mem[rd_ptr_q];
        assign valid = !empty;
    end

endmodule

// File: doc/fifo_synch_ctl.md
# fifo_synch_ctl

Parameterised synchronous FIFO, the successor to the team's fixed single-operation FIFOs. It supports a simultaneous read and write in the same cycle, and a selectable read mode: registered-output or first-word fall-through (FWFT). It also provides programmable almost-full/almost-empty thresholds, an occupancy count, and overflow/underflow error pulses. It sits between single-clock producer/consumer stages wherever back-pressure and watermark-driven flow control are needed.

## Interface
- DATA_WIDTH, 8, data word width in bits (>=1)
- DEPTH, 16, number of entries; any integer >=2, not restricted to a power of two
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (legal range 1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (legal range 0..DEPTH-1)
- FWFT, 0, read mode: 0 = registered read, 1 = first-word fall-through
- clk  input  1  clock; all state changes on the rising edge
- reset_n  input  1  synchronous, active-low reset
- write_en  input  1  write request
- read_en  input  1  read request (pop)
- d_in  input  DATA_WIDTH  write data
- d_out  output  DATA_WIDTH  read data
- valid  output  1  d_out holds a valid popped word (FWFT=0) or the valid head word (FWFT=1)
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- full / empty  output  1  count==DEPTH / count==0
- almost_full / almost_empty  output  1  watermark flags, as defined by the parameters
- overflow / underflow  output  1  single-cycle error pulses

## Operation
- Write accepted: write_en && !full. The word is stored at wr_ptr and wr_ptr advances.
- Read accepted: read_en && !empty. rd_ptr advances.
- Acceptance is evaluated against the pre-edge state. Read and write are independent, and both may be accepted in the same cycle.
- count update:
  - +1 on write only
  - -1 on read only
  - unchanged on both or neither
- Pointer wrap: explicit compare, next = (ptr==DEPTH-1) ? 0 : ptr+1. No modulo on non-power-of-two values.
- Full, both requested: read accepted, write rejected. overflow pulses; count = DEPTH-1.
- Empty, both requested: write accepted, read rejected. underflow pulses; count = 1. No bypass of d_in to d_out in either mode.
- Flags full, empty, almost_full and almost_empty are combinational decodes of the registered count.
- FWFT=0:
  - On an accepted read, d_out <= mem[rd_ptr] and valid <= 1.
  - Otherwise valid <= 0 and d_out holds its last value.
- FWFT=1:
  - d_out = mem[rd_ptr] continuously; valid = !empty.
  - read_en acknowledges the presented word; the next entry is presented in the following cycle.
  - d_out is don't-care while valid=0.
- overflow <= write_en && full; underflow <= read_en && empty. Both are registered, so they assert the cycle after the offending request, for one cycle per offending cycle.
- Memory contents are not reset.

## Timing
- Reset, sampled on the clk edge with reset_n=0:
  - wr_ptr, rd_ptr and count = 0
  - d_out = 0, valid = 0, overflow = 0, underflow = 0
  - Resulting outputs: empty=1, full=0, almost_empty=1; almost_full=0 for any legal AF_LEVEL.
- Reset mid-operation discards all stored entries. Reset has priority over any read or write in that cycle.
- Write-to-visible latency:
  - A word written at edge N is counted after edge N.
  - FWFT=1: it is on d_out with valid=1 after edge N if the FIFO was empty.
  - FWFT=0: the earliest read_en is in cycle N+1, with data after edge N+1.
- Read latency, FWFT=0: one cycle from the accepted read_en to valid/d_out.
- Full throughput: one write and one read per cycle, sustained, at any occupancy between 1 and DEPTH-1.
- No combinational path from read_en/write_en to full/empty/count. In FWFT mode, the only combinational output path is rd_ptr -> d_out.

## Test plan
- Reset then idle (DEPTH=4, AF=3, AE=1): required outputs are count=0, empty=1, almost_empty=1, full=0, almost_full=0, valid=0, d_out=0.
- Fill and drain (DEPTH=4, FWFT=0): write 0xA1..0xA4 on consecutive cycles.
  - After the 3rd write: almost_full=1. After the 4th: full=1.
  - Four reads give d_out A1, A2, A3, A4, each with valid one cycle after its read_en. Then empty=1.
- Overflow and underflow:
  - write_en while full -> overflow=1 for one cycle; count stays 4; contents are unchanged on drain.
  - read_en while empty -> underflow=1 for one cycle; valid=0.
- Simultaneous read and write:
  - At count=2: count stays 2 and order is preserved.
  - At full: count becomes 3 and overflow pulses.
  - At empty: count becomes 1 and underflow pulses.
- Wrap-around (DEPTH=5, non-power-of-two): stream 20 words with simultaneous read/write at occupancy 2. Output must match the input sequence exactly across pointer wrap.
- FWFT=1: write 0x55 into an empty FIFO.
  - Next cycle: valid=1 and d_out=0x55 with no read_en.
  - read_en -> empty=1 and valid=0.
  - Assert reset_n=0 while the FIFO holds 3 entries -> count=0 and valid=0 on the next edge.
